// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and address helpers for data_memory_ws
// Contents: state_t (IDLE, WAIT, ERR), DEFAULT_BASE_ADDR,
//           addr_to_index(), addr_valid().
// Helpers work on 64-bit values so one definition serves every ADDR_W up to 64.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  // Word index of a byte address relative to the base.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int          shift);
    return (addr - base) >> shift;
  endfunction

  // At or above the base, inside the array, and word aligned.
  function automatic logic addr_valid(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth,
                                      input int          shift);
    logic [63:0] mask;
    mask = (64'd1 << shift) - 64'd1;
    return (addr >= base) &&
           (addr_to_index(addr, base, shift) < depth) &&
           ((addr & mask) == 64'd0);
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - loadable down-counter with expire flag
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load, load_value    load the counter (takes priority over counting)
//   count               current value; decrements each edge until 0
//   expire              high while count == 1 (last wait edge)
module dmem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/data_memory_ws.sv
// rtl/data_memory_ws.sv - word RAM at BASE_ADDR with wait states, busy/done handshake and address error
// Optional feature macro: DMEM_BYTE_LANE_EN (adds byteEn write mask port).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   storeValue        write data
//   address           byte address
//   MEM_W_EN/MEM_R_EN write/read request (write wins if both)
//   byteEn            byte-lane write mask (DMEM_BYTE_LANE_EN only)
//   loadValue         registered read data, held until the next successful read
//   busy              access in progress, pipeline must freeze
//   done              one-cycle completion pulse (also for errors)
//   addrErr           one-cycle pulse with done for a rejected access
module data_memory_ws
  import dmem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   storeValue,
  input  logic [ADDR_W-1:0]   address,
  input  logic                MEM_W_EN,
  input  logic                MEM_R_EN,
`ifdef DMEM_BYTE_LANE_EN
  input  logic [DATA_W/8-1:0] byteEn,
`endif
  output logic [DATA_W-1:0]   loadValue,
  output logic                busy,
  output logic                done,
  output logic                addrErr
);

  localparam int LANES = DATA_W / 8;
  localparam int SHIFT = $clog2(LANES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LANES-1:0] be_in;
`ifdef DMEM_BYTE_LANE_EN
  assign be_in = byteEn;
`else
  assign be_in = '1;
`endif

  logic             req;
  logic             req_ok;
  logic [IDX_W-1:0] req_idx;

  assign req     = MEM_W_EN | MEM_R_EN;
  assign req_ok  = addr_valid(64'(address), 64'(BASE_ADDR), 64'(DEPTH), SHIFT);
  assign req_idx = IDX_W'(addr_to_index(64'(address), 64'(BASE_ADDR), SHIFT));

  // Captured access, used when the commit happens after wait states.
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [LANES-1:0]  be_q;
  logic              wr_q;

  state_t state, state_d;
  logic   busy_d, done_d, err_d;
  logic   commit, cnt_load;
  logic   cnt_expire;
  logic [CNT_W-1:0] cnt_value;

  dmem_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(CNT_W'(WAIT_STATES)),
    .count     (cnt_value),
    .expire    (cnt_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;
    cnt_load = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!req_ok) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            commit = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d  = WAIT;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_expire) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero-wait commit uses the live inputs; a delayed one uses the capture.
  logic              c_wr;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_data;
  logic [LANES-1:0]  c_be;

  always_comb begin
    if (state == IDLE) begin
      c_wr   = MEM_W_EN;
      c_idx  = req_idx;
      c_data = storeValue;
      c_be   = be_in;
    end else begin
      c_wr   = wr_q;
      c_idx  = idx_q;
      c_data = data_q;
      c_be   = be_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
      wr_q   <= 1'b0;
    end else if (cnt_load) begin
      idx_q  <= req_idx;
      data_q <= storeValue;
      be_q   <= be_in;
      wr_q   <= MEM_W_EN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      addrErr   <= 1'b0;
      loadValue <= '0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      addrErr <= err_d;
      if (commit && !c_wr) begin
        loadValue <= mem[c_idx];
      end
    end
  end

  // RAM is not reset; the rst gate drops a write whose commit edge
  // coincides with reset.
  always_ff @(posedge clk) begin
    if (commit && c_wr && !rst) begin
      for (int b = 0; b < LANES; b++) begin
        if (c_be[b]) begin
          mem[c_idx][b*8 +: 8] <= c_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// tb/tb_data_memory_ws.sv - scoreboard bench for data_memory_ws at 0, 2 and 3 wait states
module tb_data_memory_ws;
  import dmem_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] load;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] storeValue;
  logic [3:0]  byteEn;
  logic        w_en [3];
  logic        r_en [3];
  logic [31:0] lv   [3];
  logic        bsy  [3];
  logic        dn   [3];
  logic        ae   [3];

  int          ws [3] = '{0, 2, 3};
  logic [31:0] mdl [3][64];
  logic [31:0] mdl_load [3];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_memory_ws #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .storeValue(storeValue), .address(address),
    .MEM_W_EN(w_en[0]), .MEM_R_EN(r_en[0]),
`ifdef DMEM_BYTE_LANE_EN
    .byteEn(byteEn),
`endif
    .loadValue(lv[0]), .busy(bsy[0]), .done(dn[0]), .addrErr(ae[0])
  );

  data_memory_ws #(.WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .storeValue(storeValue), .address(address),
    .MEM_W_EN(w_en[1]), .MEM_R_EN(r_en[1]),
`ifdef DMEM_BYTE_LANE_EN
    .byteEn(byteEn),
`endif
    .loadValue(lv[1]), .busy(bsy[1]), .done(dn[1]), .addrErr(ae[1])
  );

  data_memory_ws #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst), .storeValue(storeValue), .address(address),
    .MEM_W_EN(w_en[2]), .MEM_R_EN(r_en[2]),
`ifdef DMEM_BYTE_LANE_EN
    .byteEn(byteEn),
`endif
    .loadValue(lv[2]), .busy(bsy[2]), .done(dn[2]), .addrErr(ae[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One access on instance i; called at a negedge. With poke set, a write
  // to 1040 is presented during every busy cycle and must be ignored.
  task automatic access(input int i, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit poke);
    exp_t        e;
    exp_t        got_e;
    logic        valid;
    logic [3:0]  mask;
    logic [5:0]  idx;
    int          edges;
    int          busy_n;
    string       t;

    valid = (a >= 32'd1024) && (((a - 32'd1024) >> 2) < 32'd64) && (a[1:0] == 2'b00);
    idx   = 6'((a - 32'd1024) >> 2);
`ifdef DMEM_BYTE_LANE_EN
    mask = be;
`else
    mask = 4'hF;
`endif
    if (valid && w) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) mdl[i][idx][b*8 +: 8] = d[b*8 +: 8];
    end else if (valid && r) begin
      mdl_load[i] = mdl[i][idx];
    end
    e.err  = !valid;
    e.load = mdl_load[i];
    e.lat  = valid ? ws[i] + 1 : 1;
    sb.push_back(e);

    address    = a;
    storeValue = d;
    byteEn     = be;
    w_en[i]    = w;
    r_en[i]    = r;
    @(posedge clk);
    edges = 1;
    busy_n = 0;
    #1;
    w_en[i] = 1'b0;
    r_en[i] = 1'b0;
    @(negedge clk);
    while (!dn[i] && edges < 40) begin
      if (bsy[i]) busy_n++;
      if (poke && bsy[i]) begin
        w_en[i]    = 1'b1;
        address    = 32'd1040;
        storeValue = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      edges++;
      #1;
      w_en[i] = 1'b0;
      @(negedge clk);
    end
    t = $sformatf("ws%0d_%0h", ws[i], a);
    got_e = sb.pop_front();
    if (!dn[i]) begin
      check({t, "_timeout"}, 1, 0);
    end else begin
      check({t, "_err"}, ae[i], got_e.err);
      check({t, "_load"}, lv[i], got_e.load);
      check({t, "_latency"}, edges, got_e.lat);
      check({t, "_busy_cycles"}, busy_n, got_e.err ? 0 : ws[i]);
      check({t, "_busy_at_done"}, bsy[i], 0);
    end
    if (got_e.err) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    address    = '0;
    storeValue = '0;
    byteEn     = 4'hF;
    for (int i = 0; i < 3; i++) begin
      w_en[i] = 1'b0;
      r_en[i] = 1'b0;
      mdl_load[i] = '0;
      for (int k = 0; k < 64; k++) mdl[i][k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_load%0d", i), lv[i], 0);
      check($sformatf("reset_busy%0d", i), bsy[i], 0);
      check($sformatf("reset_done%0d", i), dn[i], 0);
      check($sformatf("reset_err%0d", i), ae[i], 0);
    end
    check("reset_state", 64'(u3.state), 64'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // zero wait states, back-to-back
    access(0, 1, 0, 32'd1024, 32'd10, 4'hF, 0);
    access(0, 0, 1, 32'd1024, 32'd0, 4'hF, 0);
    check("ws0_read_10", lv[0], 32'd10);

    // two wait states, requests during busy ignored
    access(1, 1, 0, 32'd1024, 32'd10, 4'hF, 0);
    access(1, 1, 0, 32'd1040, 32'h55, 4'hF, 0);
    access(1, 0, 1, 32'd1024, 32'd0, 4'hF, 1);
    access(1, 0, 1, 32'd1040, 32'd0, 4'hF, 0);
    check("ws2_poke_ignored", lv[1], 32'h55);

    // bad addresses
    access(0, 1, 0, 32'd1029, 32'd99, 4'hF, 0);
    access(0, 1, 0, 32'd1020, 32'd99, 4'hF, 0);
    access(0, 1, 0, 32'd1024 + 32'd256, 32'd99, 4'hF, 0);
    access(0, 0, 1, 32'd1024, 32'd0, 4'hF, 0);
    access(0, 0, 1, 32'd1280 - 32'd4, 32'd0, 4'hF, 0);

    // write wins over read
    access(0, 1, 1, 32'd1028, 32'hA5, 4'hF, 0);
    access(0, 0, 1, 32'd1028, 32'd0, 4'hF, 0);
    check("both_en_read", lv[0], 32'hA5);

    // reset in the middle of a three-wait-state write
    access(2, 1, 0, 32'd1032, 32'h99, 4'hF, 0);
    access(2, 0, 1, 32'd1032, 32'd0, 4'hF, 0);
    address    = 32'd1032;
    storeValue = 32'd7;
    w_en[2]    = 1'b1;
    @(posedge clk);
    #1;
    w_en[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pre_busy", bsy[2], 1);
    rst = 1'b1;
    #1;
    check("rst_busy", bsy[2], 0);
    check("rst_done", dn[2], 0);
    check("rst_err", ae[2], 0);
    check("rst_load", lv[2], 0);
    check("rst_state", 64'(u3.state), 64'(IDLE));
    for (int i = 0; i < 3; i++) mdl_load[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(2, 0, 1, 32'd1032, 32'd0, 4'hF, 0);
    check("rst_write_dropped", lv[2], 32'h99);

`ifdef DMEM_BYTE_LANE_EN
    access(0, 1, 0, 32'd1024, 32'h1122_3344, 4'hF, 0);
    access(0, 1, 0, 32'd1024, 32'hAABB_CCDD, 4'b0101, 0);
    access(0, 0, 1, 32'd1024, 32'd0, 4'hF, 0);
    check("byte_lane_merge", lv[0], 32'h11BB_33DD);
    access(0, 1, 0, 32'd1024, 32'hFFFF_FFFF, 4'b0000, 0);
    access(0, 0, 1, 32'd1024, 32'd0, 4'hF, 0);
    check("byte_lane_none", lv[0], 32'h11BB_33DD);
`else
    access(0, 1, 0, 32'd1024, 32'hAABB_CCDD, 4'b0101, 0);
    access(0, 0, 1, 32'd1024, 32'd0, 4'hF, 0);
    check("full_word_write", lv[0], 32'hAABB_CCDD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
